dma_engine: RTL and testbench
=============================

Name: dma_engine

Overview:
- Responder end of the core's DMA command interface. Accepts a one-cycle command from the EX stage, raises busy, then moves 32-bit words between data memory and one of four PIM buffers.
- Owns the data-memory port through a req/gnt handshake while busy. The core stalls on busy and does not drive dmem during that time.

Parameters:
- XLEN, 32, data and address width.
- PIM_AW, 10, PIM buffer word-address width (1024 words per buffer).
- SIZE_W, 13, width of the byte-count field.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- dma_en_i  in  1  command strobe, single-cycle pulse
- dma_funct3_i  in  3  000 = MEM->PIM, 001 = PIM->MEM, other = illegal
- dma_sel_pim_i  in  4  one-hot PIM buffer select
- dma_size_i  in  SIZE_W  transfer length in bytes
- dma_mem_addr_i  in  XLEN  data-memory byte start address
- dma_busy_o  out  1  engine active
- dma_err_o  out  1  sticky error flag, cleared by the next accepted command
- req_dmem_o  out  1  dmem request
- gnt_dmem_i  in  1  dmem grant
- data_addr_o  out  XLEN  dmem byte address
- data_wr_data_o  out  XLEN  dmem write data
- data_size_o  out  4  byte enables
- data_read_o  out  1  dmem read
- data_write_o  out  1  dmem write
- data_rd_data_i  in  XLEN  dmem read data, valid the cycle after a granted read
- pim_sel_o  out  4  PIM buffer select, latched from the command
- pim_addr_o  out  PIM_AW  PIM word address
- pim_wr_o  out  1  PIM write
- pim_rd_o  out  1  PIM read
- pim_wdata_o  out  XLEN  PIM write data
- pim_rdata_i  in  XLEN  PIM read data, valid when pim_ready_i is high
- pim_ready_i  in  1  PIM accepts write / returns read this cycle
- dma_irq_o  out  1  done pulse (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; word counter, addresses and latched command cleared.
- Command acceptance:
  - dma_en_i is sampled only in IDLE; strobes while busy are ignored.
  - On accept, latch funct3, sel, addr and size.
  - Word count N = ceil(size/4) = (size+3)>>2.
  - Memory address is word-aligned by forcing bits [1:0] to 0.
  - PIM address starts at 0.
  - dma_busy_o is registered high the cycle after dma_en_i.
- Error cases (set dma_err_o, no transfer):
  - Illegal funct3, sel not one-hot, or size > 4*2^PIM_AW: busy pulses high for exactly 1 cycle, then IDLE.
  - Misaligned addr[1:0] != 0 sets dma_err_o but the transfer still proceeds aligned.
- size == 0: busy high 1 cycle, no memory or PIM access, no error.
- States: IDLE, M2P_RD, M2P_WR, P2M_RD, P2M_WR, DONE.
- M2P_RD:
  - Drive req_dmem_o=1, data_read_o=1, data_addr_o, data_size_o=1111.
  - Hold these until gnt_dmem_i=1, then go to M2P_WR.
- M2P_WR:
  - Drive pim_wr_o=1 with pim_wdata_o = data_rd_data_i, captured into a register on the first M2P_WR cycle.
  - Hold until pim_ready_i=1.
  - Then increment addresses and decrement the counter. Counter 0 -> DONE, else -> M2P_RD.
- P2M_RD:
  - Drive pim_rd_o=1 until pim_ready_i=1.
  - Capture pim_rdata_i, then go to P2M_WR.
- P2M_WR:
  - Drive req_dmem_o, data_write_o and data_wr_data_o until gnt_dmem_i=1.
  - Byte enables are 1111, except the last word when size[1:0] != 0: 0001 / 0011 / 0111 for size[1:0] = 1 / 2 / 3.
  - Then step as above.
- DONE: busy drops the cycle after DONE is entered; next state IDLE.
- Per-word minimum latency: 2 cycles. MEM->PIM words with zero wait states take 2N+1 cycles from accept to busy low.
- Addressing:
  - Memory address increments by 4 and wraps modulo 2^XLEN.
  - PIM address increments by 1; overflow is prevented by the size check.
- Only one of data_read_o / data_write_o / pim_rd_o / pim_wr_o is active per cycle.
- req_dmem_o is never asserted outside busy.
- Async reset mid-transfer: immediate return to IDLE, all strobes low; no partial-completion flag.

Optional Feature:
- Macro: DMA_IRQ_EN.
- Defined: dma_irq_o pulses high for exactly 1 cycle on entry to DONE, including error and size-0 completions.
- Undefined: dma_irq_o is tied 0 and no IRQ logic is synthesised.

Test Plan:
- MEM->PIM: funct3=000, sel=0010, size=16, addr=0x100, dmem words A,B,C,D, gnt always 1, ready always 1 -> PIM buffer 1 addr 0..3 = A..D; busy high 9 cycles; err=0.
- PIM->MEM: funct3=001, sel=0001, size=6, addr=0x200 -> dmem writes at 0x200 with be 1111 and at 0x204 with be 0011; busy then low.
- Backpressure: gnt held 0 for 3 cycles, pim_ready 0 for 2 cycles per word -> request and address stable while waiting; no word dropped or duplicated.
- Illegal command: funct3=010 -> busy 1 cycle, err=1, no dmem/PIM strobes. Next legal command -> err cleared.
- size=0, and a dma_en_i strobe during busy -> no accesses; second strobe ignored; counters unchanged.
- Reset asserted mid MEM->PIM at word 2 -> all outputs 0 next edge; a new command after release runs from word 0. With DMA_IRQ_EN defined, dma_irq_o is a single-cycle pulse per completion.

Source files
------------

// File: rtl/dma_engine.sv
// DMA responder: moves 32-bit words between data memory and one of four PIM buffers.
// Define DMA_IRQ_EN to get a one-cycle dma_irq_o pulse per completed command.
module dma_engine #(
  parameter int XLEN   = 32,
  parameter int PIM_AW = 10,
  parameter int SIZE_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dma_en_i,
  input  logic [2:0]        dma_funct3_i,
  input  logic [3:0]        dma_sel_pim_i,
  input  logic [SIZE_W-1:0] dma_size_i,
  input  logic [XLEN-1:0]   dma_mem_addr_i,
  output logic              dma_busy_o,
  output logic              dma_err_o,
  output logic              req_dmem_o,
  input  logic              gnt_dmem_i,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wr_data_o,
  output logic [3:0]        data_size_o,
  output logic              data_read_o,
  output logic              data_write_o,
  input  logic [XLEN-1:0]   data_rd_data_i,
  output logic [3:0]        pim_sel_o,
  output logic [PIM_AW-1:0] pim_addr_o,
  output logic              pim_wr_o,
  output logic              pim_rd_o,
  output logic [XLEN-1:0]   pim_wdata_o,
  input  logic [XLEN-1:0]   pim_rdata_i,
  input  logic              pim_ready_i,
  output logic              dma_irq_o
);

  typedef enum logic [2:0] {IDLE, M2P_RD, M2P_WR, P2M_RD, P2M_WR, DONE} state_t;

  localparam int          CNT_W     = SIZE_W - 1;
  localparam int unsigned MAX_BYTES = 4 << PIM_AW;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     mem_addr_q;
  logic [PIM_AW-1:0]   pim_addr_q;
  logic [3:0]          sel_q;
  logic [1:0]          tail_q;
  logic [XLEN-1:0]     data_q;
  logic                first_q;
  logic                err_q;

  logic                sel_onehot, cmd_bad, accept, step, last;
  logic [CNT_W-1:0]    words;
  logic [3:0]          be;

  assign sel_onehot = (dma_sel_pim_i != 4'b0000) &&
                      ((dma_sel_pim_i & (dma_sel_pim_i - 4'd1)) == 4'b0000);
  assign cmd_bad    = (dma_funct3_i[2:1] != 2'b00) || !sel_onehot ||
                      (32'(dma_size_i) > MAX_BYTES);
  assign words      = CNT_W'((32'(dma_size_i) + 32'd3) >> 2);
  assign accept     = (state_q == IDLE) && dma_en_i;
  assign last       = (cnt_q == CNT_W'(1));
  assign step       = ((state_q == M2P_WR) && pim_ready_i) ||
                      ((state_q == P2M_WR) && gnt_dmem_i);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dma_en_i) begin
          if (cmd_bad || (dma_size_i == '0)) state_d = DONE;
          else if (dma_funct3_i[0])          state_d = P2M_RD;
          else                               state_d = M2P_RD;
        end
      end
      M2P_RD:  if (gnt_dmem_i)  state_d = M2P_WR;
      M2P_WR:  if (pim_ready_i) state_d = last ? DONE : M2P_RD;
      P2M_RD:  if (pim_ready_i) state_d = P2M_WR;
      P2M_WR:  if (gnt_dmem_i)  state_d = last ? DONE : P2M_RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      pim_addr_q <= '0;
      sel_q      <= '0;
      tail_q     <= '0;
      data_q     <= '0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d == M2P_WR) && (state_q != M2P_WR);
      if (accept) begin
        sel_q      <= dma_sel_pim_i;
        mem_addr_q <= {dma_mem_addr_i[XLEN-1:2], 2'b00};
        pim_addr_q <= '0;
        cnt_q      <= words;
        tail_q     <= dma_size_i[1:0];
        err_q      <= cmd_bad || (dma_mem_addr_i[1:0] != 2'b00);
      end
      if (step) begin
        mem_addr_q <= mem_addr_q + XLEN'(4);
        pim_addr_q <= pim_addr_q + PIM_AW'(1);
        cnt_q      <= cnt_q - CNT_W'(1);
      end
      // Read data is only valid in the cycle after the grant, so hold it while PIM stalls.
      if ((state_q == M2P_WR) && first_q) data_q <= data_rd_data_i;
      if ((state_q == P2M_RD) && pim_ready_i) data_q <= pim_rdata_i;
    end
  end

  always_comb begin
    be = 4'b0000;
    if (state_q == M2P_RD) be = 4'b1111;
    if (state_q == P2M_WR) begin
      be = 4'b1111;
      if (last) begin
        unique case (tail_q)
          2'd1:    be = 4'b0001;
          2'd2:    be = 4'b0011;
          2'd3:    be = 4'b0111;
          default: be = 4'b1111;
        endcase
      end
    end
  end

  assign dma_busy_o     = (state_q != IDLE);
  assign dma_err_o      = err_q;
  assign req_dmem_o     = (state_q == M2P_RD) || (state_q == P2M_WR);
  assign data_read_o    = (state_q == M2P_RD);
  assign data_write_o   = (state_q == P2M_WR);
  assign data_addr_o    = mem_addr_q;
  assign data_wr_data_o = data_q;
  assign data_size_o    = be;
  assign pim_sel_o      = sel_q;
  assign pim_addr_o     = pim_addr_q;
  assign pim_wr_o       = (state_q == M2P_WR);
  assign pim_rd_o       = (state_q == P2M_RD);
  assign pim_wdata_o    = first_q ? data_rd_data_i : data_q;

`ifdef DMA_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= (state_d == DONE) && (state_q != DONE);
  end

  assign dma_irq_o = irq_q;
`else
  assign dma_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_dma_engine.sv
// Scoreboard bench for dma_engine: memory/PIM responder models with programmable wait states.
module tb_dma_engine;
  localparam int XLEN   = 32;
  localparam int PIM_AW = 10;
  localparam int SIZE_W = 13;
`ifdef DMA_IRQ_EN
  localparam int EXP_IRQ = 1;
`else
  localparam int EXP_IRQ = 0;
`endif

  logic              clk_i, rst_ni;
  logic              dma_en_i;
  logic [2:0]        dma_funct3_i;
  logic [3:0]        dma_sel_pim_i;
  logic [SIZE_W-1:0] dma_size_i;
  logic [XLEN-1:0]   dma_mem_addr_i;
  logic              dma_busy_o, dma_err_o, req_dmem_o, gnt_dmem_i;
  logic [XLEN-1:0]   data_addr_o, data_wr_data_o, data_rd_data_i;
  logic [3:0]        data_size_o;
  logic              data_read_o, data_write_o;
  logic [3:0]        pim_sel_o;
  logic [PIM_AW-1:0] pim_addr_o;
  logic              pim_wr_o, pim_rd_o, pim_ready_i, dma_irq_o;
  logic [XLEN-1:0]   pim_wdata_o, pim_rdata_i;

  dma_engine dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dma_en_i(dma_en_i), .dma_funct3_i(dma_funct3_i), .dma_sel_pim_i(dma_sel_pim_i),
    .dma_size_i(dma_size_i), .dma_mem_addr_i(dma_mem_addr_i),
    .dma_busy_o(dma_busy_o), .dma_err_o(dma_err_o),
    .req_dmem_o(req_dmem_o), .gnt_dmem_i(gnt_dmem_i),
    .data_addr_o(data_addr_o), .data_wr_data_o(data_wr_data_o), .data_size_o(data_size_o),
    .data_read_o(data_read_o), .data_write_o(data_write_o), .data_rd_data_i(data_rd_data_i),
    .pim_sel_o(pim_sel_o), .pim_addr_o(pim_addr_o), .pim_wr_o(pim_wr_o), .pim_rd_o(pim_rd_o),
    .pim_wdata_o(pim_wdata_o), .pim_rdata_i(pim_rdata_i), .pim_ready_i(pim_ready_i),
    .dma_irq_o(dma_irq_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct packed { logic [3:0] sel; logic [9:0] addr; logic [31:0] data; } pim_exp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [3:0] be; } dwr_exp_t;

  int checks = 0;
  int failures = 0;
  int gnt_delay = 0;
  int rdy_delay = 0;
  int n_dmem_rd = 0, n_dmem_wr = 0, n_pim_rd = 0, n_pim_wr = 0, irq_cycles = 0;

  pim_exp_t    pim_q[$];
  dwr_exp_t    dwr_q[$];
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] pim_mem [4][1024];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (dmem.exists(a)) return dmem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic int sel_idx(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return 0;
  endfunction

  function automatic int accesses();
    return n_dmem_rd + n_dmem_wr + n_pim_rd + n_pim_wr;
  endfunction

  // Memory/PIM responder and protocol monitor; observes at negedge, drives #1 after posedge.
  initial begin
    int gw, rw;
    logic fire_rd, prev_wait;
    logic [31:0] fire_addr, prev_addr, merged;
    pim_exp_t pe;
    dwr_exp_t de;
    gw = 0; rw = 0; fire_rd = 1'b0; prev_wait = 1'b0; fire_addr = '0; prev_addr = '0;
    gnt_dmem_i = 1'b0; pim_ready_i = 1'b0; data_rd_data_i = '0; pim_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (dma_irq_o) irq_cycles++;
      if (rst_ni) begin
        if (prev_wait) check("req_hold", 64'({req_dmem_o, data_addr_o}), 64'({1'b1, prev_addr}));
        check("protocol", 64'(($countones({data_read_o, data_write_o, pim_rd_o, pim_wr_o}) <= 1) &&
                              (!req_dmem_o || dma_busy_o)), 64'(1));
        if (req_dmem_o && data_read_o && gnt_dmem_i) begin
          n_dmem_rd++;
          check("rd_be", 64'(data_size_o), 64'(4'hF));
        end
        if (pim_rd_o && pim_ready_i) n_pim_rd++;
        if (pim_wr_o && pim_ready_i) begin
          n_pim_wr++;
          check("pim_q_nonempty", 64'(pim_q.size() != 0), 64'(1));
          if (pim_q.size() != 0) begin
            pe = pim_q.pop_front();
            check("pim_wr", 64'({pim_sel_o, pim_addr_o, pim_wdata_o}), 64'(pe));
          end
          pim_mem[sel_idx(pim_sel_o)][pim_addr_o] = pim_wdata_o;
        end
        if (req_dmem_o && data_write_o && gnt_dmem_i) begin
          n_dmem_wr++;
          check("dwr_q_nonempty", 64'(dwr_q.size() != 0), 64'(1));
          if (dwr_q.size() != 0) begin
            de = dwr_q.pop_front();
            check("dwr_addr_be", 64'({data_addr_o, data_size_o}), 64'({de.addr, de.be}));
            check("dwr_data", 64'(data_wr_data_o), 64'(de.data));
          end
          merged = mem_rd(data_addr_o);
          for (int b = 0; b < 4; b++) if (data_size_o[b]) merged[8*b +: 8] = data_wr_data_o[8*b +: 8];
          dmem[data_addr_o] = merged;
        end
      end
      fire_rd   = rst_ni && req_dmem_o && data_read_o && gnt_dmem_i;
      fire_addr = data_addr_o;
      prev_wait = rst_ni && req_dmem_o && !gnt_dmem_i;
      prev_addr = data_addr_o;
      @(posedge clk_i);
      #1;
      data_rd_data_i = fire_rd ? mem_rd(fire_addr) : 32'hDEAD_BEEF;
      if (req_dmem_o) begin
        gnt_dmem_i = (gw >= gnt_delay);
        gw = gnt_dmem_i ? 0 : gw + 1;
      end else begin
        gnt_dmem_i = 1'b0;
        gw = 0;
      end
      if (pim_wr_o || pim_rd_o) begin
        pim_ready_i = (rw >= rdy_delay);
        rw = pim_ready_i ? 0 : rw + 1;
      end else begin
        pim_ready_i = 1'b0;
        rw = 0;
      end
      pim_rdata_i = pim_rd_o ? pim_mem[sel_idx(pim_sel_o)][pim_addr_o] : 32'hDEAD_BEEF;
    end
  end

  // Drives a one-cycle command and pushes the transfers it should produce.
  task automatic issue(input logic [2:0] f3, input logic [3:0] sel,
                       input logic [SIZE_W-1:0] size, input logic [31:0] addr);
    int n;
    logic legal;
    logic [31:0] base;
    logic [3:0] be;
    @(posedge clk_i);
    #1;
    dma_en_i = 1'b1; dma_funct3_i = f3; dma_sel_pim_i = sel;
    dma_size_i = size; dma_mem_addr_i = addr;
    legal = (f3 == 3'b000 || f3 == 3'b001) && $onehot(sel) && (size <= 13'd4096);
    n = (int'(size) + 3) / 4;
    base = {addr[31:2], 2'b00};
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        if (f3 == 3'b000) begin
          pim_q.push_back({sel, 10'(i), mem_rd(base + 32'(4 * i))});
        end else begin
          be = 4'b1111;
          if (i == n - 1) begin
            case (size[1:0])
              2'd1: be = 4'b0001;
              2'd2: be = 4'b0011;
              2'd3: be = 4'b0111;
              default: be = 4'b1111;
            endcase
          end
          dwr_q.push_back({base + 32'(4 * i), pim_mem[sel_idx(sel)][i], be});
        end
      end
    end
    @(posedge clk_i);
    #1;
    dma_en_i = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input int exp_busy, input logic exp_err);
    int busy_cyc, irq0;
    irq0 = irq_cycles;
    busy_cyc = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk_i);
      if (!dma_busy_o) break;
      busy_cyc++;
    end
    #1;
    check({tag, "_busy_drop"}, 64'(dma_busy_o), 64'(0));
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
    check({tag, "_err"}, 64'(dma_err_o), 64'(exp_err));
    check({tag, "_irq"}, 64'(irq_cycles - irq0), 64'(EXP_IRQ));
    check({tag, "_pim_q_empty"}, 64'(pim_q.size()), 64'(0));
    check({tag, "_dwr_q_empty"}, 64'(dwr_q.size()), 64'(0));
  endtask

  initial begin
    int acc0, rd0, wr0;
    rst_ni = 1'b0; dma_en_i = 1'b0; dma_funct3_i = '0; dma_sel_pim_i = '0;
    dma_size_i = '0; dma_mem_addr_i = '0;
    for (int b = 0; b < 4; b++) for (int w = 0; w < 1024; w++) pim_mem[b][w] = 32'h5000_0000 | 32'(b * 4096 + w);
    dmem[32'h100] = 32'hAAAA_0001; dmem[32'h104] = 32'hBBBB_0002;
    dmem[32'h108] = 32'hCCCC_0003; dmem[32'h10C] = 32'hDDDD_0004;
    pim_mem[0][0] = 32'h1111_2222; pim_mem[0][1] = 32'h3333_4444;

    repeat (3) @(negedge clk_i);
    check("reset_ctrl", 64'({dma_busy_o, dma_err_o, req_dmem_o, data_read_o, data_write_o, pim_wr_o,
                             pim_rd_o, dma_irq_o, data_size_o, pim_sel_o, pim_addr_o}), 64'(0));
    check("reset_data", 64'({data_addr_o, data_wr_data_o}), 64'(0));
    check("reset_pim_wdata", 64'(pim_wdata_o), 64'(0));
    rst_ni = 1'b1;

    // MEM->PIM, zero wait states: 2N+1 busy cycles
    issue(3'b000, 4'b0010, 13'd16, 32'h100);
    finish_cmd("m2p", 9, 1'b0);
    check("pim1_w0", 64'(pim_mem[1][0]), 64'(32'hAAAA_0001));
    check("pim1_w3", 64'(pim_mem[1][3]), 64'(32'hDDDD_0004));

    // PIM->MEM with a 2-byte tail
    issue(3'b001, 4'b0001, 13'd6, 32'h200);
    finish_cmd("p2m", 5, 1'b0);
    check("dmem_200", 64'(mem_rd(32'h200)), 64'(32'h1111_2222));
    check("dmem_204", 64'(mem_rd(32'h204)), 64'(32'h3333_4444 & 32'h0000_FFFF | (32'h204 ^ 32'hA5A5_0000) & 32'hFFFF_0000));

    // Backpressure in both directions
    gnt_delay = 3; rdy_delay = 2;
    rd0 = n_dmem_rd; wr0 = n_pim_wr;
    issue(3'b000, 4'b0100, 13'd12, 32'h300);
    finish_cmd("bp_m2p", 22, 1'b0);
    check("bp_m2p_reads", 64'(n_dmem_rd - rd0), 64'(3));
    check("bp_m2p_writes", 64'(n_pim_wr - wr0), 64'(3));
    issue(3'b001, 4'b0100, 13'd8, 32'h403);
    finish_cmd("bp_p2m_misaligned", 15, 1'b1);
    gnt_delay = 0; rdy_delay = 0;

    // Error commands, stickiness, and clearing by the next accepted command
    acc0 = accesses();
    issue(3'b010, 4'b0001, 13'd8, 32'h700);
    finish_cmd("bad_f3", 1, 1'b1);
    check("bad_f3_no_access", 64'(accesses() - acc0), 64'(0));
    issue(3'b000, 4'b0001, 13'd4, 32'h100);
    finish_cmd("err_clear", 3, 1'b0);
    acc0 = accesses();
    issue(3'b000, 4'b0011, 13'd4, 32'h100);
    finish_cmd("bad_sel", 1, 1'b1);
    repeat (3) @(negedge clk_i);
    check("err_sticky", 64'(dma_err_o), 64'(1));
    issue(3'b001, 4'b0001, 13'd4097, 32'h100);
    finish_cmd("bad_size", 1, 1'b1);
    check("bad_no_access", 64'(accesses() - acc0), 64'(0));

    // Largest legal size and address wrap
    issue(3'b000, 4'b1000, 13'd4096, 32'h1000);
    finish_cmd("max_size", 2049, 1'b0);
    issue(3'b000, 4'b1000, 13'd16, 32'hFFFF_FFF8);
    finish_cmd("wrap", 9, 1'b0);

    // size 0, then a strobe while busy that must be ignored
    acc0 = accesses();
    issue(3'b000, 4'b0001, 13'd0, 32'h100);
    finish_cmd("size0", 1, 1'b0);
    check("size0_no_access", 64'(accesses() - acc0), 64'(0));
    issue(3'b000, 4'b0100, 13'd8, 32'h100);
    @(posedge clk_i);
    #1;
    dma_en_i = 1'b1; dma_funct3_i = 3'b001; dma_sel_pim_i = 4'b0001; dma_size_i = 13'd4;
    @(posedge clk_i);
    #1;
    dma_en_i = 1'b0;
    finish_cmd("busy_strobe", 3, 1'b0);
    repeat (3) @(negedge clk_i);
    check("busy_strobe_idle", 64'(dma_busy_o), 64'(0));

    // Reset mid MEM->PIM at word 2, then a fresh command from word 0
    wr0 = n_pim_wr;
    issue(3'b000, 4'b0001, 13'd16, 32'h500);
    for (int k = 0; k < 200 && n_pim_wr < wr0 + 2; k++) @(negedge clk_i);
    check("reset_at_word2", 64'(n_pim_wr - wr0), 64'(2));
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midreset_ctrl", 64'({dma_busy_o, dma_err_o, req_dmem_o, data_read_o, data_write_o, pim_wr_o,
                                pim_rd_o, dma_irq_o, data_size_o, pim_sel_o, pim_addr_o}), 64'(0));
    check("midreset_addr", 64'(data_addr_o), 64'(0));
    pim_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    issue(3'b000, 4'b0001, 13'd8, 32'h600);
    finish_cmd("after_reset", 5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
